uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
- Frame-sequencing FSM for the UART receiver.
- Detects the start bit and times every bit period from Prescale.
- Pulses the enables of the start, parity and stop checkers, the data sampler and the deserializer.
- Collects checker results and issues a single-cycle data_valid per good frame. Sits between RX_IN and the RX checker/deserializer datapath in the RX clock domain.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESC_W, 6, width of Prescale and edge_cnt

Ports:
CLK  in  1  RX oversampling clock
RST  in  1  async active-low reset
RX_IN  in  1  serial line, idle high (already synchronised)
PAR_EN  in  1  parity bit present in frame
Prescale  in  PRESC_W  oversampling ratio per bit; legal 8, 16, 32
sampled_bit  in  1  majority-voted bit from data sampler
strt_glitch  in  1  start checker result, registered, valid cycle after strt_chk_en
par_err  in  1  parity checker result, registered, valid cycle after par_chk_en
stop_error  in  1  stop checker result, registered, valid cycle after stop_check_en
dat_samp_en  out  1  data sampler enable
edge_cnt  out  PRESC_W  position inside current bit, 0..Prescale-1
bit_cnt  out  4  bit index in frame (0 = start)
strt_chk_en  out  1  one-cycle pulse
deser_en  out  1  one-cycle pulse per data bit
par_chk_en  out  1  one-cycle pulse
stop_check_en  out  1  one-cycle pulse
data_valid  out  1  one-cycle pulse, frame accepted
busy  out  1  high while a frame is in progress

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. RST mid-frame aborts immediately. No data_valid for the aborted frame. After release, wait for a new falling level on RX_IN.
- States: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - edge_cnt increments every cycle outside IDLE.
  - At edge_cnt == Prescale-1, edge_cnt wraps to 0 and bit_cnt increments.
  - Both counters are held at 0 in IDLE.
- Sample point: SP = Prescale/2 + 2, the cycle after the sampler's third vote edge (Prescale/2+1). A check enable pulses for exactly one cycle at edge_cnt == SP. The FSM reads the registered checker result at edge_cnt == Prescale-1.
- dat_samp_en is 1 in every state except IDLE.
- IDLE:
  - RX_IN==0 -> START next cycle, edge_cnt=0, bit_cnt=0, busy=1.
  - Otherwise stay; busy=0.
- START:
  - strt_chk_en pulses at SP.
  - At the last edge: strt_glitch==1 -> IDLE, no further pulses; else -> DATA with bit_cnt=1.
- DATA:
  - deser_en pulses at SP for bit_cnt 1..DATA_WIDTH (LSB first).
  - At the last edge of bit DATA_WIDTH -> PARITY if PAR_EN, else STOP.
- PARITY:
  - par_chk_en pulses at SP.
  - At the last edge -> STOP; par_err is latched into an internal frame_err flag.
- STOP:
  - stop_check_en pulses at SP.
  - At the last edge: data_valid=1 for one cycle only if stop_error==0 and frame_err==0.
  - Then go to START if RX_IN==0 (back-to-back frame, counters restart at 0, busy stays 1); otherwise go to IDLE.
- frame_err clears on entry to START.
- PAR_EN and Prescale are sampled when leaving IDLE and held for the frame; changes mid-frame are ignored.
- Illegal Prescale (not 8/16/32): behaviour unspecified; no assertion required.
- Frame length in cycles: Prescale × (1 + DATA_WIDTH + PAR_EN + 1).

Decomposition:
- Package uart_rx_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - legal prescale constants PRESC_8/16/32;
  - DATA_WIDTH default.
- Sub-module uart_rx_edge_bit_cnt: edge_cnt/bit_cnt with enable, wrap at Prescale-1, synchronous clear. The FSM stays in uart_rx_ctrl.

Test Plan:
1. Prescale=8, PAR_EN=0, frame 0xA5 with good stop.
   - Exactly 8 deser_en pulses, each at edge_cnt==6.
   - data_valid high one cycle at cycle 79 after the start falling edge; busy falls next cycle.
2. Prescale=16, PAR_EN=1, par_err forced 1 after par_chk_en.
   - par_chk_en pulses once at bit_cnt==9, edge_cnt==10.
   - data_valid stays 0; FSM returns to IDLE.
3. RX_IN low 3 cycles, strt_glitch=1 at Prescale=8.
   - FSM returns to IDLE at the end of the start bit.
   - No deser_en, no stop_check_en, no data_valid.
4. Stop bit 0 (stop_error=1), Prescale=32.
   - stop_check_en pulses at edge_cnt==18 of bit 9; data_valid=0.
   - Next state START, because RX_IN is still low.
5. Two back-to-back frames 0x3C, 0xC3 with no idle gap, Prescale=8.
   - Two data_valid pulses exactly 80 cycles apart; busy continuously 1.
6. Assert RST during DATA (bit_cnt=4).
   - All outputs 0 immediately.
   - After release with RX_IN high, stays IDLE; no data_valid.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART receive controller:
//               frame state encoding, legal oversampling ratios, defaults and
//               the sample-point helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESC_W_DEF    = 6;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // The sampler votes on edges presc/2-1..presc/2+1; the checkers are
    // enabled on the cycle after the last vote.
    function automatic int sample_point(input int presc);
        return (presc / 2) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl_if
// Description : Bundle between the RX frame controller and the RX datapath
//               (line input, configuration, checker results, enables and
//               counters). master = controller, slave = datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) ();

    logic               RX_IN;
    logic               PAR_EN;
    logic [PRESC_W-1:0] Prescale;
    logic               sampled_bit;
    logic               strt_glitch;
    logic               par_err;
    logic               stop_error;

    logic               dat_samp_en;
    logic [PRESC_W-1:0] edge_cnt;
    logic [3:0]         bit_cnt;
    logic               strt_chk_en;
    logic               deser_en;
    logic               par_chk_en;
    logic               stop_check_en;
    logic               data_valid;
    logic               busy;

    modport master (
        input  RX_IN, PAR_EN, Prescale, sampled_bit,
               strt_glitch, par_err, stop_error,
        output dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en,
               par_chk_en, stop_check_en, data_valid, busy
    );

    modport slave (
        output RX_IN, PAR_EN, Prescale, sampled_bit,
               strt_glitch, par_err, stop_error,
        input  dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en,
               par_chk_en, stop_check_en, data_valid, busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_edge_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_edge_bit_cnt
// Description : Oversampling edge counter and bit counter. edge_cnt wraps at
//               prescale-1 and advances bit_cnt; synchronous clear wins over
//               enable.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  wire logic               CLK,
    input  wire logic               RST,
    input  wire logic               i_en,
    input  wire logic               i_clr,
    input  wire logic [PRESC_W-1:0] i_prescale,
    output logic      [PRESC_W-1:0] o_edge_cnt,
    output logic      [3:0]         o_bit_cnt,
    output logic                    o_last_edge
);

    logic [PRESC_W-1:0] r_edge_cnt;
    logic [3:0]         r_bit_cnt;
    logic               w_last_edge;

    assign w_last_edge = (r_edge_cnt == (i_prescale - PRESC_W'(1)));

    // Advance the position inside the bit; roll into the next bit at the last edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_clr) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_en) begin
            if (w_last_edge) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
            end
        end
    end

    assign o_edge_cnt  = r_edge_cnt;
    assign o_bit_cnt   = r_bit_cnt;
    assign o_last_edge = w_last_edge;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive frame sequencer. Detects the start level,
//               times each bit from Prescale, pulses the checker/deserializer
//               enables at the sample point and issues data_valid for frames
//               with good start, parity and stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESC_W    = PRESC_W_DEF
) (
    input  wire logic      CLK,
    input  wire logic      RST,
    uart_rx_ctrl_if.master bus
);

    localparam logic [3:0] c_LAST_DATA_BIT = 4'(DATA_WIDTH);

    rx_state_e          r_state;
    rx_state_e          w_state_nxt;
    logic [PRESC_W-1:0] r_prescale;
    logic               r_par_en;
    logic               r_frame_err;

    logic [PRESC_W-1:0] w_edge_cnt;
    logic [3:0]         w_bit_cnt;
    logic               w_last_edge;
    logic [PRESC_W-1:0] w_sp;
    logic               w_at_sp;
    logic               w_cnt_en;
    logic               w_cnt_clr;

    logic               w_dat_samp_en;
    logic               w_strt_chk_en;
    logic               w_deser_en;
    logic               w_par_chk_en;
    logic               w_stop_check_en;
    logic               w_data_valid;
    logic               w_busy;

    assign w_sp     = PRESC_W'(sample_point(int'(r_prescale)));
    assign w_at_sp  = (w_edge_cnt == w_sp);
    assign w_cnt_en = (r_state != IDLE);

    uart_rx_edge_bit_cnt #(
        .PRESC_W (PRESC_W)
    ) u_cnt (
        .CLK         (CLK),
        .RST         (RST),
        .i_en        (w_cnt_en),
        .i_clr       (w_cnt_clr),
        .i_prescale  (r_prescale),
        .o_edge_cnt  (w_edge_cnt),
        .o_bit_cnt   (w_bit_cnt),
        .o_last_edge (w_last_edge)
    );

    // Frame state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Freeze the frame configuration as the line leaves idle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_prescale <= PRESC_W'(PRESC_8);
            r_par_en   <= 1'b0;
        end else if ((r_state == IDLE) && !bus.RX_IN) begin
            r_prescale <= bus.Prescale;
            r_par_en   <= bus.PAR_EN;
        end
    end

    // Parity verdict is carried into the stop bit, where the frame is accepted
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_frame_err <= 1'b0;
        end else if ((w_state_nxt == START) && (r_state != START)) begin
            r_frame_err <= 1'b0;
        end else if ((r_state == PARITY) && w_last_edge) begin
            r_frame_err <= bus.par_err;
        end
    end

    // Next-state, counter control and enable pulses
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_clr       = 1'b0;
        w_dat_samp_en   = 1'b0;
        w_strt_chk_en   = 1'b0;
        w_deser_en      = 1'b0;
        w_par_chk_en    = 1'b0;
        w_stop_check_en = 1'b0;
        w_data_valid    = 1'b0;
        w_busy          = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.RX_IN) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                w_dat_samp_en = 1'b1;
                w_busy        = 1'b1;
                w_strt_chk_en = w_at_sp;
                if (w_last_edge) begin
                    if (bus.strt_glitch) begin
                        w_state_nxt = IDLE;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                w_dat_samp_en = 1'b1;
                w_busy        = 1'b1;
                w_deser_en    = w_at_sp;
                if (w_last_edge && (w_bit_cnt == c_LAST_DATA_BIT)) begin
                    w_state_nxt = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_dat_samp_en = 1'b1;
                w_busy        = 1'b1;
                w_par_chk_en  = w_at_sp;
                if (w_last_edge) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                w_dat_samp_en   = 1'b1;
                w_busy          = 1'b1;
                w_stop_check_en = w_at_sp;
                if (w_last_edge) begin
                    w_data_valid = !bus.stop_error && !r_frame_err;
                    w_cnt_clr    = 1'b1;
                    // A low line here is already the next start bit
                    w_state_nxt  = bus.RX_IN ? IDLE : START;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    assign bus.dat_samp_en   = w_dat_samp_en;
    assign bus.edge_cnt      = w_edge_cnt;
    assign bus.bit_cnt       = w_bit_cnt;
    assign bus.strt_chk_en   = w_strt_chk_en;
    assign bus.deser_en      = w_deser_en;
    assign bus.par_chk_en    = w_par_chk_en;
    assign bus.stop_check_en = w_stop_check_en;
    assign bus.data_valid    = w_data_valid;
    assign bus.busy          = w_busy;

endmodule
`default_nettype wire
